fetch_ctrl: RTL and testbench

// - Sequences instruction fetch for the 5-stage MIPS pipeline. Owns the PC register and the
//   req/ack handshake to instruction memory, and presents {pc, instr, valid} to the IF/ID register.
// - Accepts next-PC redirects (j/jal/jr/jalr/taken branch) resolved in ID, and hazard stalls.
// - MIPS delay slot is honoured: a redirect never kills the fetch already issued or held.

---
 rtl/fetch_ctrl.sv | 141 ++++++++++++++
 tb/tb_fetch_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : Instruction-fetch sequencer for a 5-stage MIPS pipeline.
//               Owns the PC, drives the req/ack handshake to instruction
//               memory and presents {pc, instr, valid} to the IF/ID register.
//               Takes next-PC redirects resolved in ID and hazard stalls.
//               The MIPS delay slot is honoured: a redirect never disturbs
//               the fetch already in flight or the word already presented.
// Ports       : clk, reset        - clock, synchronous active-high reset
//               stall_i           - IF/ID hold; presented word not consumed
//               redirect_valid/pc - ID-stage next-PC override (1-cycle pulse)
//               imem_req/addr     - fetch request / address (held until ack)
//               imem_ack/rdata    - memory response
//               if_valid/pc/instr - word presented to IF/ID
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_FETCH = 2'd1,
        S_VALID = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;          // address of the fetch in flight
    logic [31:0] r_next_pc;     // address of the fetch after it
    logic        r_if_valid;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_instr;

    logic [31:0] w_redir_pc;
    logic [31:0] w_nxt;
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_ack;

    assign w_redir_pc = {redirect_pc[31:2], 2'b00};
    assign w_nxt      = redirect_valid ? w_redir_pc : r_next_pc;

    // Request is combinational so that an unstalled S_VALID cycle can issue
    // the next fetch immediately, giving one instruction per cycle with a
    // zero-wait memory. Reset drops the request in the very cycle it is seen.
    always_comb begin
        w_req  = 1'b0;
        w_addr = r_pc;
        case (r_state)
            S_FETCH: w_req = 1'b1;
            S_VALID: begin
                if (!stall_i) begin
                    w_req  = 1'b1;
                    w_addr = w_nxt;
                end
            end
            default: w_req = 1'b0;
        endcase
        if (reset) begin
            w_req = 1'b0;
        end
    end

    assign w_ack = w_req & imem_ack;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_RESET;
            r_pc       <= RESET_PC;
            r_next_pc  <= RESET_PC;
            r_if_valid <= 1'b0;
            r_if_pc    <= RESET_PC;
            r_if_instr <= 32'h0;
        end else begin
            case (r_state)
                S_RESET: begin
                    r_state <= S_FETCH;
                    if (redirect_valid) begin
                        r_next_pc <= w_redir_pc;
                    end
                end
                S_FETCH: begin
                    if (w_ack) begin
                        r_if_valid <= 1'b1;
                        r_if_pc    <= r_pc;
                        r_if_instr <= imem_rdata;
                        r_state    <= S_VALID;
                        // The word in flight is the delay slot; a redirect
                        // seen now steers the fetch after it.
                        r_next_pc  <= redirect_valid ? w_redir_pc : r_pc + 32'd4;
                    end else if (redirect_valid) begin
                        r_next_pc  <= w_redir_pc;
                    end
                end
                S_VALID: begin
                    if (stall_i) begin
                        if (redirect_valid) begin
                            r_next_pc <= w_redir_pc;
                        end
                    end else begin
                        r_pc <= w_nxt;
                        if (w_ack) begin
                            r_if_pc    <= w_nxt;
                            r_if_instr <= imem_rdata;
                            // A redirect here was already used as this
                            // fetch's address, so continue sequentially.
                            r_next_pc  <= w_nxt + 32'd4;
                        end else begin
                            r_if_valid <= 1'b0;
                            r_state    <= S_FETCH;
                            r_next_pc  <= w_nxt;
                        end
                    end
                end
                default: r_state <= S_RESET;
            endcase
        end
    end

    assign imem_req  = w_req;
    assign imem_addr = w_addr;
    assign if_valid  = r_if_valid;
    assign if_pc     = r_if_pc;
    assign if_instr  = r_if_instr;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_ctrl
// Description : Self-checking bench for fetch_ctrl. A memory model acks
//               requests after a per-fetch wait count; the expected fetch
//               order is queued up front and each ack queues the word that
//               must appear on the IF/ID outputs after the edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

    localparam logic [31:0] C_RESET_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_i;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    fetch_ctrl #(.RESET_PC(C_RESET_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall_i        (stall_i),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          dly;
    } fe_t;

    fe_t         exp_q[$];     // expected fetch order with memory wait counts
    logic [31:0] pres_q[$];    // addresses expected on if_pc after an ack

    int          n_checks = 0;
    int          n_fail   = 0;
    logic        pending  = 1'b0;
    int          wait_left = 0;
    logic        hold_valid = 1'b0;
    logic [31:0] hold_addr  = 32'h0;
    logic        exp_valid  = 1'b0;
    logic [31:0] cur_pc     = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] a, input int d);
        fe_t e;
        e.addr = a;
        e.dly  = d;
        exp_q.push_back(e);
    endtask

    // One clock cycle, entered and left at a negedge.
    task automatic tick(input logic rst, input logic st, input logic rv,
                        input logic [31:0] rpc, input logic fack);
        logic acked;
        reset          = rst;
        stall_i        = st;
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_ack       = 1'b0;
        #1;
        if (rst) begin
            check("req_in_reset", {31'h0, imem_req}, 32'h0);
            imem_ack = fack;
        end else if (imem_req) begin
            if (!pending) begin
                pending   = 1'b1;
                wait_left = (exp_q.size() > 0) ? exp_q[0].dly : 1000;
            end
            if (wait_left > 0) begin
                wait_left--;
            end else begin
                imem_ack = 1'b1;
            end
        end
        imem_rdata = mem_word(imem_addr);
        if (!rst && st && exp_valid) begin
            check("req_stall", {31'h0, imem_req}, 32'h0);
        end
        if (!rst && imem_req && hold_valid) begin
            check("addr_hold", imem_addr, hold_addr);
        end
        acked = !rst && imem_req && imem_ack;
        if (acked) begin
            pending = 1'b0;
            if (exp_q.size() > 0) begin
                check("fetch_addr", imem_addr, exp_q[0].addr);
                pres_q.push_back(exp_q[0].addr);
                void'(exp_q.pop_front());
            end else begin
                check("fetch_unexpected", imem_addr, 32'hFFFF_FFFF);
            end
        end
        hold_valid = !rst && imem_req && !imem_ack;
        hold_addr  = imem_addr;
        @(posedge clk);
        #1;
        if (rst) begin
            pending    = 1'b0;
            hold_valid = 1'b0;
            exp_valid  = 1'b0;
            check("rst_valid", {31'h0, if_valid}, 32'h0);
            check("rst_pc", if_pc, C_RESET_PC);
            check("rst_instr", if_instr, 32'h0);
        end else if (acked && pres_q.size() > 0) begin
            cur_pc    = pres_q.pop_front();
            exp_valid = 1'b1;
            check("if_valid", {31'h0, if_valid}, 32'h1);
            check("if_pc", if_pc, cur_pc);
            check("if_instr", if_instr, mem_word(cur_pc));
        end else begin
            exp_valid = st && exp_valid;
            check("bubble_valid", {31'h0, if_valid}, {31'h0, exp_valid});
            if (exp_valid) begin
                check("held_pc", if_pc, cur_pc);
                check("held_instr", if_instr, mem_word(cur_pc));
            end
        end
        @(negedge clk);
    endtask

    initial begin
        reset          = 1'b1;
        stall_i        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_ack       = 1'b0;
        imem_rdata     = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

        // Zero-wait memory, no stall: 3000, 3004, 3008 back to back.
        push(32'h0000_3000, 0);
        push(32'h0000_3004, 0);
        push(32'h0000_3008, 0);
        repeat (4) tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

        // Wait states, stall, delay-slot redirect, masked target, wrap.
        push(32'h0000_3000, 0);
        push(32'h0000_3004, 3);
        push(32'h0000_3008, 0);
        push(32'h0000_300C, 1);
        push(32'h0000_3400, 0);
        push(32'h0000_3404, 0);
        push(32'hFFFF_FFFC, 0);
        push(32'h0000_0000, 0);
        push(32'h0000_0004, 0);
        repeat (7) tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);   // through 3008 presented
        repeat (2) tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);   // stall on 3008
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);              // 300C issued, waits
        tick(1'b0, 1'b0, 1'b1, 32'h0000_3403, 1'b0);      // redirect while 300C in flight
        repeat (2) tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);   // 3400, 3404
        tick(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);      // stalled redirect, repeated
        tick(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
        repeat (3) tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);   // FFFFFFFC, 0, 4
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);              // fetch of 8 left waiting
        tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);              // reset with ack same cycle

        // Restart from the reset vector.
        push(32'h0000_3000, 0);
        push(32'h0000_3004, 0);
        repeat (3) tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

        check("drain_fetch", exp_q.size(), 32'h0);
        check("drain_present", pres_q.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
